cnn_stream_frame_sink: RTL and testbench
========================================

// Module: cnn_stream_frame_sink
// PURPOSE
// - Receiving end of the CNN layer pixel stream (valid/pxl, channel-major, raster order, no backpressure).
// - Captures one full multi-channel frame (CHANNEL_NUM_IN x IMAGE_HEIGHT x IMAGE_WIDTH) from a layer output.
// - Tracks column, row and channel position, and flags frame completion.
// - Replays the stored frame on request, so a layer output can be checked or fed to the next layer in hardware.
// PARAMETERS
// - DATA_WIDTH      32  pixel word width
// - IMAGE_WIDTH     16  pixels per row
// - IMAGE_HEIGHT    16  rows per channel
// - CHANNEL_NUM_IN  4   channels per frame
// - Derived: TOTAL = CHANNEL_NUM_IN*IMAGE_WIDTH*IMAGE_HEIGHT; AW = $clog2(TOTAL)
// PORTS
// - clk          in   1           single clock; all logic on posedge
// - reset        in   1           synchronous, active-high
// - valid_in     in   1           input beat strobe from the upstream layer
// - pxl_in       in   DATA_WIDTH  input pixel
// - rd_en        in   1           request next stored pixel (honoured only when frame_ready)
// - pxl_out      out  DATA_WIDTH  replayed pixel
// - valid_out    out  1           pxl_out is valid this cycle
// - col_idx      out  clog2(W)    column of the next expected input beat
// - row_idx      out  clog2(H)    row of the next expected input beat
// - ch_idx       out  clog2(C)    channel of the next expected input beat
// - frame_done   out  1           one-cycle pulse after the last beat of a frame is captured
// - frame_ready  out  1           frame stored and not fully drained
// - overflow     out  1           sticky: a valid_in beat was dropped
// BEHAVIOUR
// - Reset values: pxl_out=0, valid_out=0, indices=0, frame_done=0, frame_ready=0, overflow=0, state=CAPTURE, wr_ptr=rd_ptr=0. RAM contents are not cleared.
// - FSM: CAPTURE -> HOLD -> DRAIN -> CAPTURE.
// - CAPTURE
//   - Each valid_in writes mem[wr_ptr] and increments wr_ptr.
//   - col_idx wraps at W-1 and increments row_idx; row_idx wraps at H-1 and increments ch_idx.
//   - The beat with wr_ptr==TOTAL-1 moves the FSM to HOLD, resets wr_ptr and indices to 0, and asserts frame_done for exactly the next cycle.
//   - rd_en is ignored in CAPTURE.
// - HOLD: frame_ready=1. rd_en=1 reads mem[rd_ptr] and moves the FSM to DRAIN.
// - DRAIN
//   - Each rd_en reads mem[rd_ptr] and increments rd_ptr.
//   - Read latency is exactly 1: pxl_out and valid_out are registered and valid the cycle after rd_en.
//   - rd_en=0 gives valid_out=0 the next cycle; pxl_out holds its last value.
//   - The read with rd_ptr==TOTAL-1 returns the FSM to CAPTURE, clears rd_ptr, and drops frame_ready the next cycle.
//   - The last valid_out still appears one cycle after that read.
// - valid_in in HOLD or DRAIN: beat is dropped, nothing is written, overflow=1 (held until reset).
// - valid_in and rd_en may arrive together on the cycle that ends DRAIN. The beat is dropped, because the FSM is still in DRAIN that cycle.
// - rd_en while frame_ready=0: no read, valid_out=0, no error.
// - reset mid-capture or mid-drain: pointers, indices and FSM return to reset state; the partial frame is abandoned and frame_done does not pulse.
// STRUCTURE
// - Shared package cnn_pkg: state encoding (CAPTURE=2'd0, HOLD=2'd1, DRAIN=2'd2) and the TOTAL/AW derivation function.
// - Sub-module cnn_frame_ram: simple dual-port RAM, one write port and one read port, registered read, DEPTH=TOTAL, width DATA_WIDTH.
// - Top level holds the FSM, pointers, index counters and flags.
// TESTING
// - Default params, 1024 beats of pxl_in=index, valid_in every cycle -> frame_done pulses once, the cycle after beat 1023; indices return to 0.
// - Same stimulus with valid_in toggling 1/0 every cycle -> only 1024 valid beats are stored; beats 15 and 16 give col_idx 15->0 and row_idx 0->1.
// - After capture, hold rd_en=1 for 1024 cycles -> valid_out for 1024 cycles, starting 1 cycle after the first rd_en; pxl_out = 0..1023 in order; frame_ready falls after the final read.
// - During HOLD, drive valid_in=1 with pxl_in=32'hDEAD -> overflow=1 and stays 1; a subsequent drain shows no 32'hDEAD in the data.
// - Assert reset after 500 captured beats, then send a fresh 1024-beat frame -> frame_done only after the new 1024th beat; drain returns the new frame.
// - Gapped drain (rd_en 1,0,0,1...) -> valid_out mirrors rd_en delayed by 1 cycle; data order is preserved.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN frame sink: FSM state encoding and frame sizing helpers.
package cnn_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  function automatic int unsigned frame_total(input int unsigned c, input int unsigned h,
                                              input int unsigned w);
    return c * h * w;
  endfunction

  // Never returns 0 so that a degenerate dimension of 1 still yields a legal port width.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
module cnn_frame_ram
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned AW         = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register holds its value between reads; only it is reset, not the array.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cnn_stream_frame_sink.sv
// Captures one channel-major CNN frame from a valid/pxl stream and replays it on rd_en.
module cnn_stream_frame_sink
  import cnn_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned IMAGE_WIDTH    = 16,
  parameter  int unsigned IMAGE_HEIGHT   = 16,
  parameter  int unsigned CHANNEL_NUM_IN = 4,
  localparam int unsigned TOTAL = frame_total(CHANNEL_NUM_IN, IMAGE_HEIGHT, IMAGE_WIDTH),
  localparam int unsigned AW    = addr_width(TOTAL),
  localparam int unsigned XW    = addr_width(IMAGE_WIDTH),
  localparam int unsigned YW    = addr_width(IMAGE_HEIGHT),
  localparam int unsigned CW    = addr_width(CHANNEL_NUM_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic [XW-1:0]         col_idx,
  output logic [YW-1:0]         row_idx,
  output logic [CW-1:0]         ch_idx,
  output logic                  frame_done,
  output logic                  frame_ready,
  output logic                  overflow
);

  state_e          state_d, state_q;
  logic [AW-1:0]   wr_ptr_d, wr_ptr_q;
  logic [AW-1:0]   rd_ptr_d, rd_ptr_q;
  logic [XW-1:0]   col_idx_d, col_idx_q;
  logic [YW-1:0]   row_idx_d, row_idx_q;
  logic [CW-1:0]   ch_idx_d, ch_idx_q;
  logic            frame_done_d, frame_done_q;
  logic            frame_ready_d, frame_ready_q;
  logic            valid_out_d, valid_out_q;
  logic            overflow_d, overflow_q;
  logic            ram_we, ram_re;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    col_idx_d    = col_idx_q;
    row_idx_d    = row_idx_q;
    ch_idx_d     = ch_idx_q;
    frame_done_d = 1'b0;
    valid_out_d  = 1'b0;
    overflow_d   = overflow_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;

    unique case (state_q)
      CAPTURE: begin
        if (valid_in) begin
          ram_we = 1'b1;
          if (wr_ptr_q == AW'(TOTAL - 1)) begin
            wr_ptr_d     = '0;
            col_idx_d    = '0;
            row_idx_d    = '0;
            ch_idx_d     = '0;
            frame_done_d = 1'b1;
            state_d      = HOLD;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (col_idx_q == XW'(IMAGE_WIDTH - 1)) begin
              col_idx_d = '0;
              if (row_idx_q == YW'(IMAGE_HEIGHT - 1)) begin
                row_idx_d = '0;
                ch_idx_d  = ch_idx_q + CW'(1);
              end else begin
                row_idx_d = row_idx_q + YW'(1);
              end
            end else begin
              col_idx_d = col_idx_q + XW'(1);
            end
          end
        end
      end
      HOLD, DRAIN: begin
        // Input beats cannot be stored while a frame is pending, including the final drain cycle.
        if (valid_in) overflow_d = 1'b1;
        if (rd_en) begin
          ram_re      = 1'b1;
          valid_out_d = 1'b1;
          if (rd_ptr_q == AW'(TOTAL - 1)) begin
            rd_ptr_d = '0;
            state_d  = CAPTURE;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            state_d  = DRAIN;
          end
        end
      end
      default: state_d = CAPTURE;
    endcase

    frame_ready_d = (state_d != CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CAPTURE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      col_idx_q     <= '0;
      row_idx_q     <= '0;
      ch_idx_q      <= '0;
      frame_done_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      valid_out_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      col_idx_q     <= col_idx_d;
      row_idx_q     <= row_idx_d;
      ch_idx_q      <= ch_idx_d;
      frame_done_q  <= frame_done_d;
      frame_ready_q <= frame_ready_d;
      valid_out_q   <= valid_out_d;
      overflow_q    <= overflow_d;
    end
  end

  cnn_frame_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (TOTAL),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (pxl_in),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_q),
    .rd_data (pxl_out)
  );

  assign valid_out   = valid_out_q;
  assign col_idx     = col_idx_q;
  assign row_idx     = row_idx_q;
  assign ch_idx      = ch_idx_q;
  assign frame_done  = frame_done_q;
  assign frame_ready = frame_ready_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_cnn_stream_frame_sink.sv
// Self-checking bench for cnn_stream_frame_sink against a frame-level behavioural model.
module tb_cnn_stream_frame_sink;

  localparam int W = 16, H = 16, C = 4, TOTAL = W * H * C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] pxl_in = '0;
  logic        rd_en = 1'b0;
  logic [31:0] pxl_out;
  logic        valid_out;
  logic [3:0]  col_idx;
  logic [3:0]  row_idx;
  logic [1:0]  ch_idx;
  logic        frame_done, frame_ready, overflow;

  int errors = 0;
  int checks = 0;

  // Model: a frame is either being collected (stored=0) or sitting in the buffer awaiting reads.
  logic [31:0] frame_m [TOTAL];
  int          wcount, rcount;
  bit          stored, ovf_m, done_m, valid_m;
  logic [31:0] pxl_m;

  cnn_stream_frame_sink dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .rd_en(rd_en),
    .pxl_out(pxl_out), .valid_out(valid_out), .col_idx(col_idx), .row_idx(row_idx),
    .ch_idx(ch_idx), .frame_done(frame_done), .frame_ready(frame_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_col(); return 4'(wcount % W); endfunction
  function automatic logic [3:0] exp_row(); return 4'((wcount / W) % H); endfunction
  function automatic logic [1:0] exp_ch();  return 2'(wcount / (W * H)); endfunction

  task automatic model_reset();
    wcount = 0; rcount = 0; stored = 0; ovf_m = 0; done_m = 0; valid_m = 0; pxl_m = '0;
  endtask

  // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit v, input logic [31:0] p, input bit r);
    bit was_stored;
    was_stored = stored;
    valid_in = v; pxl_in = p; rd_en = r;
    @(posedge clk); #1;
    valid_in = 1'b0; rd_en = 1'b0;
    done_m = 0; valid_m = 0;
    if (r && was_stored) begin
      valid_m = 1; pxl_m = frame_m[rcount]; rcount++;
      if (rcount == TOTAL) begin rcount = 0; stored = 0; end
    end
    if (v) begin
      if (was_stored) ovf_m = 1;
      else begin
        frame_m[wcount] = p; wcount++;
        if (wcount == TOTAL) begin wcount = 0; stored = 1; done_m = 1; end
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    valid_in = 1'b1; pxl_in = 32'h1234; rd_en = 1'b1;
    do_reset(3);
    valid_in = 1'b0; rd_en = 1'b0;
    checks++; if (pxl_out !== 32'd0) begin errors++; $display("FAIL reset_pxl_out got %h exp 0", pxl_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b exp 0", valid_out); end
    checks++; if ({col_idx, row_idx, ch_idx} !== 10'd0) begin errors++; $display("FAIL reset_idx got %0d/%0d/%0d exp 0/0/0", col_idx, row_idx, ch_idx); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset_frame_ready got %b exp 0", frame_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_capture_contiguous();
    int pulses = 0;
    for (int i = 0; i < TOTAL; i++) begin
      drive(1'b1, 32'(i), 1'(i % 2));
      if (frame_done === 1'b1) pulses++;
      checks++; if ({col_idx, row_idx, ch_idx} !== {exp_col(), exp_row(), exp_ch()}) begin errors++;
        $display("FAIL cap_idx beat %0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, col_idx, row_idx, ch_idx, exp_col(), exp_row(), exp_ch()); end
      checks++; if (frame_done !== done_m) begin errors++; $display("FAIL cap_done beat %0d got %b exp %b", i, frame_done, done_m); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL cap_rd_ignored beat %0d got %b exp 0", i, valid_out); end
    end
    drive(1'b0, '0, 1'b0);
    checks++; if (pulses != 1 || frame_done !== 1'b0) begin errors++; $display("FAIL cap_done_once pulses %0d exp 1, done now %b exp 0", pulses, frame_done); end
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL cap_ready got %b exp 1", frame_ready); end
  endtask

  task automatic test_drain_full();
    logic [31:0] last;
    for (int i = 0; i < TOTAL; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (valid_out !== 1'b1 || pxl_out !== 32'(i) || pxl_out !== pxl_m) begin errors++;
        $display("FAIL drain_data read %0d got v=%b d=%0d exp v=1 d=%0d", i, valid_out, pxl_out, i); end
      checks++; if (frame_ready !== stored) begin errors++; $display("FAIL drain_ready read %0d got %b exp %b", i, frame_ready, stored); end
    end
    last = pxl_out;
    drive(1'b0, '0, 1'b1);
    checks++; if (valid_out !== 1'b0 || pxl_out !== last) begin errors++;
      $display("FAIL rd_not_ready got v=%b d=%h exp v=0 d=%h", valid_out, pxl_out, last); end
  endtask

  task automatic test_gapped_capture();
    for (int i = 0; i < 2 * TOTAL; i++) begin
      drive(1'(i % 2 == 0), $urandom, 1'b0);
      checks++; if ({col_idx, row_idx, ch_idx} !== {exp_col(), exp_row(), exp_ch()}) begin errors++;
        $display("FAIL gap_idx cycle %0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, col_idx, row_idx, ch_idx, exp_col(), exp_row(), exp_ch()); end
      checks++; if (frame_done !== done_m) begin errors++; $display("FAIL gap_done cycle %0d got %b exp %b", i, frame_done, done_m); end
    end
  endtask

  task automatic test_overflow_hold();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hDEAD, 1'b0);
      checks++; if (overflow !== 1'b1 || frame_ready !== 1'b1 || {col_idx, row_idx, ch_idx} !== 10'd0) begin errors++;
        $display("FAIL ovf_hold cycle %0d got ovf=%b rdy=%b idx=%0d/%0d/%0d exp 1/1/0", i, overflow, frame_ready, col_idx, row_idx, ch_idx); end
    end
  endtask

  task automatic test_gapped_drain();
    int k = 0;
    while (stored && k < 5000) begin
      drive(1'b0, '0, 1'(k % 3 == 0));
      checks++; if (valid_out !== valid_m || (valid_m && pxl_out !== pxl_m)) begin errors++;
        $display("FAIL gdrain cycle %0d got v=%b d=%h exp v=%b d=%h", k, valid_out, pxl_out, valid_m, pxl_m); end
      checks++; if (valid_out === 1'b1 && pxl_out === 32'hDEAD) begin errors++; $display("FAIL gdrain_dead cycle %0d got %h", k, pxl_out); end
      k++;
    end
    checks++; if (stored) begin errors++; $display("FAIL gdrain_bound cycles %0d exp drain complete", k); end
    checks++; if (overflow !== 1'b1 || frame_ready !== 1'b0) begin errors++;
      $display("FAIL gdrain_end got ovf=%b rdy=%b exp ovf=1 rdy=0", overflow, frame_ready); end
  endtask

  task automatic test_end_of_drain_collision();
    for (int i = 0; i < TOTAL; i++) drive(1'b1, $urandom, 1'b0);
    for (int i = 0; i < TOTAL; i++) begin
      drive(1'(i == TOTAL - 1), 32'hBEEF, 1'b1);
      checks++; if (valid_out !== 1'b1 || pxl_out !== pxl_m) begin errors++;
        $display("FAIL coll_data read %0d got v=%b d=%h exp v=1 d=%h", i, valid_out, pxl_out, pxl_m); end
    end
    checks++; if ({col_idx, row_idx, ch_idx} !== 10'd0 || frame_ready !== 1'b0) begin errors++;
      $display("FAIL coll_dropped got idx=%0d/%0d/%0d rdy=%b exp 0/0/0 rdy=0", col_idx, row_idx, ch_idx, frame_ready); end
  endtask

  task automatic test_reset_mid_capture();
    do_reset(2);
    for (int i = 0; i < 500; i++) drive(1'b1, $urandom, 1'b0);
    checks++; if (col_idx !== 4'd4 || row_idx !== 4'd15 || ch_idx !== 2'd1) begin errors++;
      $display("FAIL mid_idx got %0d/%0d/%0d exp 4/15/1", col_idx, row_idx, ch_idx); end
    do_reset(1);
    checks++; if ({col_idx, row_idx, ch_idx} !== 10'd0 || frame_done !== 1'b0) begin errors++;
      $display("FAIL mid_reset got idx=%0d/%0d/%0d done=%b exp 0 done=0", col_idx, row_idx, ch_idx, frame_done); end
    for (int i = 0; i < TOTAL; i++) begin
      drive(1'b1, $urandom, 1'b0);
      checks++; if (frame_done !== done_m) begin errors++; $display("FAIL mid_done beat %0d got %b exp %b", i, frame_done, done_m); end
    end
    for (int i = 0; i < TOTAL; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (valid_out !== 1'b1 || pxl_out !== pxl_m) begin errors++;
        $display("FAIL mid_drain read %0d got v=%b d=%h exp d=%h", i, valid_out, pxl_out, pxl_m); end
    end
  endtask

  task automatic test_random_mixed();
    for (int i = 0; i < 6000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
      checks++; if ({valid_out, frame_done, frame_ready, overflow} !== {valid_m, done_m, stored, ovf_m}) begin errors++;
        $display("FAIL rnd_flags cycle %0d got v/d/r/o=%b%b%b%b exp %b%b%b%b", i, valid_out, frame_done, frame_ready, overflow, valid_m, done_m, stored, ovf_m); end
      checks++; if (pxl_out !== pxl_m || {col_idx, row_idx, ch_idx} !== {exp_col(), exp_row(), exp_ch()}) begin errors++;
        $display("FAIL rnd_data cycle %0d got d=%h idx=%0d/%0d/%0d exp d=%h idx=%0d/%0d/%0d", i, pxl_out, col_idx, row_idx, ch_idx, pxl_m, exp_col(), exp_row(), exp_ch()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_capture_contiguous();
    test_drain_full();
    test_gapped_capture();
    test_overflow_hold();
    test_gapped_drain();
    test_end_of_drain_collision();
    test_reset_mid_capture();
    do_reset(1);
    test_random_mixed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
